// File: rtl/poseidon2_pkg.sv
// Shared types and constants for the Poseidon2 message loader.
// POSEIDON2_LOADER_MODCHECK_EN selects the optional field-range comparator.
package poseidon2_pkg;

  localparam logic [255:0] P2_MODULUS =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam int P2_MAX_WORDS = 15;

  typedef logic [255:0] felem_t;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } loader_state_e;

endpackage

// File: rtl/poseidon2_field_range_chk.sv
// Combinational check that a field element is strictly below the Poseidon2 modulus.
// Only built when POSEIDON2_LOADER_MODCHECK_EN is defined.
`ifdef POSEIDON2_LOADER_MODCHECK_EN
module poseidon2_field_range_chk
  import poseidon2_pkg::*;
(
  input  felem_t elem,
  output logic   in_range
);

  assign in_range = (elem < P2_MODULUS);

endmodule
`endif

// File: rtl/poseidon2_msg_loader.sv
// Buffers a valid/ready stream of field elements, hands the message to the Poseidon2
// core and returns the hash on a valid/ready port. POSEIDON2_LOADER_MODCHECK_EN adds a modulus check.
module poseidon2_msg_loader
  import poseidon2_pkg::*;
#(
  parameter int MAX_WORDS = P2_MAX_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [255:0] s_data,
  input  logic         s_last,
  output logic         start,
  output logic [3:0]   size,
  output logic [255:0] data_in_0,
  output logic [255:0] data_in_1,
  output logic [255:0] data_in_2,
  output logic [255:0] data_in_3,
  output logic [255:0] data_in_4,
  output logic [255:0] data_in_5,
  output logic [255:0] data_in_6,
  output logic [255:0] data_in_7,
  output logic [255:0] data_in_8,
  output logic [255:0] data_in_9,
  output logic [255:0] data_in_10,
  output logic [255:0] data_in_11,
  output logic [255:0] data_in_12,
  output logic [255:0] data_in_13,
  output logic [255:0] data_in_14,
  input  logic         done,
  input  logic [255:0] hash_out,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [255:0] m_hash,
  output logic         err,
  output logic         busy
);

  localparam int          NUM_SLOTS = 15;
  localparam logic [3:0]  LAST_IDX  = 4'(MAX_WORDS - 1);

  loader_state_e state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    size_q;
  logic          start_q;
  logic          err_q;
  logic          m_valid_q;
  felem_t        m_hash_q;
  felem_t        buf_q [NUM_SLOTS];
  logic          in_range;

`ifdef POSEIDON2_LOADER_MODCHECK_EN
  poseidon2_field_range_chk u_range_chk (
    .elem     (s_data),
    .in_range (in_range)
  );
`else
  assign in_range = 1'b1;
`endif

  // Both ports are valid/ready: a transfer happens on a rising edge where valid and ready
  // are both 1; ready depends only on registered state, never on valid.
  assign s_ready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign busy    = (state_q != ST_LOAD);
  assign start   = start_q;
  assign err     = err_q;
  assign size    = size_q;
  assign m_valid = m_valid_q;
  assign m_hash  = m_hash_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      size_q    <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_hash_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            if (!in_range) begin
              // Out-of-field element: reject the whole message, resync on its last beat.
              err_q   <= 1'b1;
              cnt_q   <= '0;
              for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
              state_q <= s_last ? ST_LOAD : ST_DRAIN;
            end else if (s_last) begin
              buf_q[cnt_q] <= s_data;
              size_q       <= cnt_q + 4'd1;
              start_q      <= 1'b1;
              state_q      <= ST_ISSUE;
            end else if (cnt_q == LAST_IDX) begin
              err_q   <= 1'b1;
              cnt_q   <= '0;
              for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
              state_q <= ST_DRAIN;
            end else begin
              buf_q[cnt_q] <= s_data;
              cnt_q        <= cnt_q + 4'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (s_valid && s_last) begin
            cnt_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (done) begin
            m_hash_q  <= hash_out;
            m_valid_q <= 1'b1;
            state_q   <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
            size_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) buf_q[i] <= '0;
            state_q   <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign data_in_0  = buf_q[0];
  assign data_in_1  = buf_q[1];
  assign data_in_2  = buf_q[2];
  assign data_in_3  = buf_q[3];
  assign data_in_4  = buf_q[4];
  assign data_in_5  = buf_q[5];
  assign data_in_6  = buf_q[6];
  assign data_in_7  = buf_q[7];
  assign data_in_8  = buf_q[8];
  assign data_in_9  = buf_q[9];
  assign data_in_10 = buf_q[10];
  assign data_in_11 = buf_q[11];
  assign data_in_12 = buf_q[12];
  assign data_in_13 = buf_q[13];
  assign data_in_14 = buf_q[14];

endmodule

// File: tb/tb_poseidon2_msg_loader.sv
// Directed bench for poseidon2_msg_loader: a scoreboard queue holds expected start
// payloads, hashes and err pulses; a negedge monitor pops and compares them.
module tb_poseidon2_msg_loader;
  import poseidon2_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         start;
  logic [3:0]   size;
  logic [255:0] din [15];
  logic         done = 1'b0;
  logic [255:0] hash_out = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [255:0] m_hash;
  logic         err;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] exp_q[$];
  logic [255:0] exp_hash_q[$];
  logic [0:0]   exp_err_q[$];
  logic [255:0] vec [15];

  poseidon2_msg_loader dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .start(start), .size(size),
    .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
    .data_in_4(din[4]), .data_in_5(din[5]), .data_in_6(din[6]), .data_in_7(din[7]),
    .data_in_8(din[8]), .data_in_9(din[9]), .data_in_10(din[10]), .data_in_11(din[11]),
    .data_in_12(din[12]), .data_in_13(din[13]), .data_in_14(din[14]),
    .done(done), .hash_out(hash_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_hash(m_hash),
    .err(err), .busy(busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        if (exp_q.size() < 16) check("unexpected_start", 256'(start), 256'(0));
        else begin
          check("start_size", 256'(size), exp_q.pop_front());
          for (int k = 0; k < 15; k++) check($sformatf("data_in_%0d", k), din[k], exp_q.pop_front());
        end
      end
      if (err) begin
        if (exp_err_q.size() == 0) check("unexpected_err", 256'(err), 256'(0));
        else check("err_pulse", 256'(err), 256'(exp_err_q.pop_front()));
      end
      if (m_valid && m_ready) begin
        if (exp_hash_q.size() == 0) check("unexpected_result", 256'(m_valid), 256'(0));
        else check("m_hash", m_hash, exp_hash_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_start(input int sz);
    exp_q.push_back(256'(sz));
    for (int k = 0; k < 15; k++) exp_q.push_back((k < sz) ? vec[k] : '0);
  endtask

  task automatic send_beat(input logic [255:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) check("s_ready_timeout", 256'(s_ready), 256'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic send_msg(input int n);
    for (int k = 0; k < n; k++) send_beat(vec[k], (k == n - 1));
  endtask

  task automatic wait_start();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk); n++;
      if (start) seen = 1'b1;
    end
    check("start_seen", 256'(seen), 256'(1));
  endtask

  task automatic core_done(input logic [255:0] h, input logic expect_valid);
    @(negedge clk);
    done = 1'b1; hash_out = h;
    @(posedge clk); #1;
    done = 1'b0; hash_out = '0;
    check("m_valid_after_done", 256'(m_valid), 256'(expect_valid));
  endtask

  task automatic accept_result();
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin @(negedge clk); n++; end
    check("m_valid_wait", 256'(m_valid), 256'(1));
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("s_ready_after_accept", 256'(s_ready), 256'(1));
    check("m_valid_after_accept", 256'(m_valid), 256'(0));
  endtask

  task automatic run_hash(input logic [255:0] h);
    wait_start();
    exp_hash_q.push_back(h);
    core_done(h, 1'b1);
    accept_result();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 256'(s_ready), 256'(1));
    check("rst_start",   256'(start),   256'(0));
    check("rst_m_valid", 256'(m_valid), 256'(0));
    check("rst_err",     256'(err),     256'(0));
    check("rst_busy",    256'(busy),    256'(0));
    check("rst_size",    256'(size),    256'(0));
    check("rst_m_hash",  m_hash,        256'(0));

    // single-element message
    vec[0] = 256'd5;
    push_start(1);
    send_msg(1);
    check("start_latency", 256'(start), 256'(1));
    run_hash(256'hABCD);

    // full 15-element message
    for (int k = 0; k < 15; k++) vec[k] = 256'(k + 1);
    push_start(15);
    send_msg(15);
    run_hash(256'h1515);

    // overflow: 16 beats, last only on the 16th
    for (int k = 0; k < 14; k++) send_beat(256'(100 + k), 1'b0);
    exp_err_q.push_back(1'b1);
    send_beat(256'd114, 1'b0);
    check("overflow_err", 256'(err), 256'(1));
    send_beat(256'd115, 1'b1);
    check("overflow_no_start", 256'(start), 256'(0));
    check("overflow_s_ready", 256'(s_ready), 256'(1));
    vec[0] = 256'd7; vec[1] = 256'd8;
    push_start(2);
    send_msg(2);
    run_hash(256'h78);

    // backpressure on the result port, then stray done in LOAD
    vec[0] = 256'd9;
    push_start(1);
    send_msg(1);
    wait_start();
    exp_hash_q.push_back(256'h1234);
    core_done(256'h1234, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_m_hash",  m_hash,            256'h1234);
      check("bp_s_ready", 256'(s_ready),     256'(0));
      check("bp_m_valid", 256'(m_valid),     256'(1));
    end
    accept_result();
    core_done(256'hDEAD, 1'b0);
    core_done(256'hBEEF, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stray_done_m_valid", 256'(m_valid), 256'(0));
    end

    // reset while waiting on the core
    for (int k = 0; k < 3; k++) vec[k] = 256'(k + 1);
    push_start(3);
    send_msg(3);
    wait_start();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("wrst_start",   256'(start),   256'(0));
    check("wrst_size",    256'(size),    256'(0));
    check("wrst_busy",    256'(busy),    256'(0));
    check("wrst_m_valid", 256'(m_valid), 256'(0));
    check("wrst_s_ready", 256'(s_ready), 256'(1));
    for (int k = 0; k < 3; k++) check($sformatf("wrst_data_in_%0d", k), din[k], 256'(0));
    core_done(256'h5555, 1'b0);
    @(negedge clk);
    check("wrst_late_done", 256'(m_valid), 256'(0));

`ifdef POSEIDON2_LOADER_MODCHECK_EN
    exp_err_q.push_back(1'b1);
    send_beat(P2_MODULUS, 1'b1);
    check("mod_err", 256'(err), 256'(1));
    check("mod_no_start", 256'(start), 256'(0));
    vec[0] = P2_MODULUS - 256'd1;
    push_start(1);
    send_msg(1);
    run_hash(256'h77);
`endif

    repeat (5) @(negedge clk);
    check("exp_q_empty",      256'(exp_q.size()),      256'(0));
    check("exp_hash_q_empty", 256'(exp_hash_q.size()), 256'(0));
    check("exp_err_q_empty",  256'(exp_err_q.size()),  256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
